control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/ctrl_pkg.sv | 71 +++++++
 rtl/op_decode.sv | 30 +++
 rtl/control_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the control sequencer.
//   state_e    - sequencer states; the value is what appears on `step`
//   OPC_*      - instruction opcodes (ir[DW-1:DW-5])
//   ALU_*      - ALU operation codes driven on op_sel during T4
//   op_class() - opcode -> register / immediate / illegal class
//   strobe_t   - datapath strobes, field order matches the top-level port list
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_PL_A = 4'd7,
    ST_PL_B = 4'd8,
    ST_PL_C = 4'd9
  } state_e;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [1:0] {
    CLS_BAD = 2'd0,
    CLS_REG = 2'd1,
    CLS_IMM = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: return CLS_REG;
      OPC_ADDI, OPC_ANDI, OPC_ORI:       return CLS_IMM;
      default:                           return CLS_BAD;
    endcase
  endfunction

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic mdr_in;
    logic read;
    logic mdr_out;
    logic inc_pc;
    logic zlo_in;
    logic zlo_out;
    logic pc_in;
    logic ir_in;
    logic y_in;
    logic c_out;
    logic r_out;
    logic r_in;
    logic gra;
    logic grb;
    logic grc;
    logic ba_out;
  } strobe_t;

endpackage

// File: rtl/op_decode.sv
// op_decode: opcode -> instruction class and ALU operation.
//   opcode - ir[DW-1:DW-5]
//   imm    - immediate-class instruction
//   op_sel - ALU operation for T4 (immediate forms map onto their register op)
//   legal  - opcode is one of the supported instructions
module op_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       imm,
  output logic [4:0] op_sel,
  output logic       legal
);

  op_class_e cls;

  always_comb begin
    cls   = op_class(opcode);
    legal = (cls != CLS_BAD);
    imm   = (cls == CLS_IMM);
    case (opcode)
      OPC_ADD, OPC_ADDI: op_sel = ALU_ADD;
      OPC_SUB:           op_sel = ALU_SUB;
      OPC_AND, OPC_ANDI: op_sel = ALU_AND;
      OPC_OR,  OPC_ORI:  op_sel = ALU_OR;
      default:           op_sel = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore fetch/execute sequencer with register preload.
//   clk, clr        - clock, asynchronous active-low reset
//   start, run      - single instruction / continuous mode
//   preload_req/sel - preload one register from memory
//   mem_rdy         - memory read data valid (stalls PL_B and T1)
//   ir              - instruction register, opcode in the top 5 bits
//   datapath strobes, op_sel, r_rd - decoded purely from registered state
//   step, busy, done, illegal, fault - status
// Optional: define CTRL_WATCHDOG_EN to bound memory stalls to WD_CYCLES
// cycles; on expiry fault is set and the sequencer returns to IDLE.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int DW        = 32,
  parameter int NREG      = 16,
  parameter int WD_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     run,
  input  logic                     preload_req,
  input  logic [$clog2(NREG)-1:0]  preload_sel,
  input  logic                     mem_rdy,
  input  logic [DW-1:0]            ir,
  output logic                     pc_out,
  output logic                     mar_in,
  output logic                     mdr_in,
  output logic                     read,
  output logic                     mdr_out,
  output logic                     inc_pc,
  output logic                     zlo_in,
  output logic                     zlo_out,
  output logic                     pc_in,
  output logic                     ir_in,
  output logic                     y_in,
  output logic                     c_out,
  output logic                     r_out,
  output logic                     r_in,
  output logic                     gra,
  output logic                     grb,
  output logic                     grc,
  output logic                     ba_out,
  output logic [4:0]               op_sel,
  output logic [NREG-1:0]          r_rd,
  output logic [3:0]               step,
  output logic                     busy,
  output logic                     done,
  output logic                     illegal,
  output logic                     fault
);

  state_e                   state, nxt;
  logic [$clog2(NREG)-1:0]  sel_q;
  logic                     imm_q;
  logic [4:0]               alu_q;
  logic                     dec_imm, dec_legal;
  logic [4:0]               dec_op;
  logic                     wd_hit;
  strobe_t                  stb;
  logic                     unused_ir;

  assign unused_ir = ^ir[DW-6:0];

  op_decode u_dec (
    .opcode (ir[DW-1:DW-5]),
    .imm    (dec_imm),
    .op_sel (dec_op),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= ST_IDLE;
      sel_q   <= '0;
      imm_q   <= 1'b0;
      alu_q   <= ALU_NOP;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      // Target register is captured on entry so sel may move during the preload.
      if (state == ST_IDLE && preload_req) sel_q <= preload_sel;
      // Decode is frozen at T2 exit; T3/T4 strobes come from these copies.
      if (state == ST_T2) begin
        imm_q <= dec_imm;
        alu_q <= dec_op;
        if (!dec_legal) illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt    = state;
    stb    = '0;
    op_sel = ALU_NOP;
    r_rd   = '0;
    case (state)
      ST_IDLE: begin
        if (preload_req) nxt = ST_PL_A;
        else if (start)  nxt = ST_T0;
      end
      ST_PL_A: begin
        stb.pc_out = 1'b1; stb.mar_in = 1'b1;
        nxt = ST_PL_B;
      end
      ST_PL_B: begin
        stb.read = 1'b1; stb.mdr_in = 1'b1;
        if (mem_rdy)     nxt = ST_PL_C;
        else if (wd_hit) nxt = ST_IDLE;
      end
      ST_PL_C: begin
        stb.inc_pc = 1'b1; stb.mdr_out = 1'b1;
        r_rd[sel_q] = 1'b1;
        nxt = ST_IDLE;
      end
      ST_T0: begin
        stb.pc_out = 1'b1; stb.mar_in = 1'b1; stb.inc_pc = 1'b1; stb.zlo_in = 1'b1;
        nxt = ST_T1;
      end
      ST_T1: begin
        stb.zlo_out = 1'b1; stb.pc_in = 1'b1; stb.read = 1'b1; stb.mdr_in = 1'b1;
        if (mem_rdy)     nxt = ST_T2;
        else if (wd_hit) nxt = ST_IDLE;
      end
      ST_T2: begin
        stb.mdr_out = 1'b1; stb.ir_in = 1'b1;
        nxt = dec_legal ? ST_T3 : ST_IDLE;
      end
      ST_T3: begin
        stb.grb = 1'b1; stb.r_out = 1'b1; stb.y_in = 1'b1; stb.ba_out = imm_q;
        nxt = ST_T4;
      end
      ST_T4: begin
        stb.zlo_in = 1'b1;
        stb.c_out  = imm_q;
        stb.grc    = !imm_q;
        stb.r_out  = !imm_q;
        op_sel     = alu_q;
        nxt = ST_T5;
      end
      ST_T5: begin
        stb.zlo_out = 1'b1; stb.gra = 1'b1; stb.r_in = 1'b1;
        nxt = run ? ST_T0 : ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  assign {pc_out, mar_in, mdr_in, read, mdr_out, inc_pc, zlo_in, zlo_out, pc_in,
          ir_in, y_in, c_out, r_out, r_in, gra, grb, grc, ba_out} = stb;

  assign step = state;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_T5);

`ifdef CTRL_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;
  logic           stall;

  // Counts consecutive not-ready cycles of the current memory wait only.
  assign stall  = (state == ST_PL_B || state == ST_T1) && !mem_rdy;
  assign wd_hit = stall && (wd_cnt == WDW'(WD_CYCLES - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wd_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      wd_cnt <= (stall && !wd_hit) ? wd_cnt + 1'b1 : '0;
      if (wd_hit) fault <= 1'b1;
    end
  end
`else
  logic unused_wd;
  assign unused_wd = WD_CYCLES[0];
  assign wd_hit    = 1'b0;
  assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed + randomized checks of control_sequencer
// against a cycle-list reference model built from the instruction timing rules.
module tb_control_sequencer;
  import ctrl_pkg::*;

  localparam int WD = 15;

  logic        clk = 1'b0;
  logic        clr, start, run, preload_req, mem_rdy;
  logic [3:0]  preload_sel;
  logic [31:0] ir;
  logic        pc_out, mar_in, mdr_in, read, mdr_out, inc_pc, zlo_in, zlo_out, pc_in;
  logic        ir_in, y_in, c_out, r_out, r_in, gra, grb, grc, ba_out;
  logic [4:0]  op_sel;
  logic [15:0] r_rd;
  logic [3:0]  step;
  logic        busy, done, illegal, fault;
  logic [17:0] stb_act;

  control_sequencer #(.DW(32), .NREG(16), .WD_CYCLES(WD)) dut (
    .clk(clk), .clr(clr), .start(start), .run(run), .preload_req(preload_req),
    .preload_sel(preload_sel), .mem_rdy(mem_rdy), .ir(ir),
    .pc_out(pc_out), .mar_in(mar_in), .mdr_in(mdr_in), .read(read), .mdr_out(mdr_out),
    .inc_pc(inc_pc), .zlo_in(zlo_in), .zlo_out(zlo_out), .pc_in(pc_in), .ir_in(ir_in),
    .y_in(y_in), .c_out(c_out), .r_out(r_out), .r_in(r_in), .gra(gra), .grb(grb),
    .grc(grc), .ba_out(ba_out), .op_sel(op_sel), .r_rd(r_rd), .step(step),
    .busy(busy), .done(done), .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;

  assign stb_act = {pc_out, mar_in, mdr_in, read, mdr_out, inc_pc, zlo_in, zlo_out, pc_in,
                    ir_in, y_in, c_out, r_out, r_in, gra, grb, grc, ba_out};

  localparam logic [17:0] S_PC_OUT  = 18'h1 << 17, S_MAR_IN  = 18'h1 << 16;
  localparam logic [17:0] S_MDR_IN  = 18'h1 << 15, S_READ    = 18'h1 << 14;
  localparam logic [17:0] S_MDR_OUT = 18'h1 << 13, S_INC_PC  = 18'h1 << 12;
  localparam logic [17:0] S_ZLO_IN  = 18'h1 << 11, S_ZLO_OUT = 18'h1 << 10;
  localparam logic [17:0] S_PC_IN   = 18'h1 << 9,  S_IR_IN   = 18'h1 << 8;
  localparam logic [17:0] S_Y_IN    = 18'h1 << 7,  S_C_OUT   = 18'h1 << 6;
  localparam logic [17:0] S_R_OUT   = 18'h1 << 5,  S_R_IN    = 18'h1 << 4;
  localparam logic [17:0] S_GRA     = 18'h1 << 3,  S_GRB     = 18'h1 << 2;
  localparam logic [17:0] S_GRC     = 18'h1 << 1,  S_BA_OUT  = 18'h1;

  // One entry per clock cycle: inputs to drive and outputs expected that cycle.
  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] stb;
    logic [4:0]  ops;
    logic [15:0] rrd;
    logic        done, ill, flt;
    logic        start, run, preq, rdy;
    logic [3:0]  sel;
    logic [31:0] ir;
  } rec_t;

  rec_t q[$];
  rec_t tmp;
  int   tests = 0, fails = 0, cyc = 0;
  bit   ill_m = 0, flt_m = 0, chain_m = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // ALU code the instruction set assigns to an opcode, -1 when unsupported.
  function automatic int alu_of(input logic [4:0] opc);
    case (opc)
      5'b00011, 5'b01100: return 3;
      5'b00100:           return 4;
      5'b00101, 5'b01101: return 5;
      5'b00110, 5'b01110: return 6;
      default:            return -1;
    endcase
  endfunction

  function automatic bit is_imm(input logic [4:0] opc);
    return (opc == 5'b01100) || (opc == 5'b01101) || (opc == 5'b01110);
  endfunction

  function automatic logic [4:0] pick_op(input int k);
    case (k)
      0: return 5'b00011; 1: return 5'b00100; 2: return 5'b00101; 3: return 5'b00110;
      4: return 5'b01100; 5: return 5'b01101; 6: return 5'b01110;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic rec_t base();
    rec_t r;
    r = '0;
    r.rdy = 1'b1; r.ill = ill_m; r.flt = flt_m; r.sel = 4'($urandom);
    return r;
  endfunction

  function automatic void gen_idle();
    rec_t r;
    r = base();
    r.st = ST_IDLE;
    q.push_back(r);
  endfunction

  function automatic void gen_instr(input logic [4:0] opc, input int stall,
                                    input bit run_after, input bit hold);
    rec_t r;
    int   a;
    bit   imm;
    a   = alu_of(opc);
    imm = is_imm(opc);
    r = base();
    r.ir = {opc, 27'($urandom)};
    r.run = run_after;
    r.start = hold;
    if (!chain_m) begin
      r.st = ST_IDLE; r.start = 1'b1; q.push_back(r); r.start = hold;
    end
    r.st = ST_T0; r.stb = S_PC_OUT | S_MAR_IN | S_INC_PC | S_ZLO_IN; q.push_back(r);
    r.st = ST_T1; r.stb = S_ZLO_OUT | S_PC_IN | S_READ | S_MDR_IN;
    for (int i = 0; i < stall; i++) begin r.rdy = 1'b0; q.push_back(r); end
    r.rdy = 1'b1; q.push_back(r);
    r.st = ST_T2; r.stb = S_MDR_OUT | S_IR_IN; q.push_back(r);
    if (a < 0) begin
      ill_m = 1'b1; chain_m = 1'b0;
      return;
    end
    r.st = ST_T3; r.stb = S_GRB | S_R_OUT | S_Y_IN | (imm ? S_BA_OUT : 18'h0); q.push_back(r);
    r.st = ST_T4; r.ops = 5'(a);
    r.stb = S_ZLO_IN | (imm ? S_C_OUT : (S_GRC | S_R_OUT)); q.push_back(r);
    r.st = ST_T5; r.ops = 5'h0; r.done = 1'b1;
    r.stb = S_ZLO_OUT | S_GRA | S_R_IN; q.push_back(r);
    chain_m = run_after;
  endfunction

  function automatic void gen_preload(input logic [3:0] sel, input int stall, input bit also_start);
    rec_t r;
    r = base();
    r.st = ST_IDLE; r.preq = 1'b1; r.sel = sel; r.start = also_start; q.push_back(r);
    r = base();
    r.st = ST_PL_A; r.stb = S_PC_OUT | S_MAR_IN; q.push_back(r);
    r.st = ST_PL_B; r.stb = S_READ | S_MDR_IN;
    for (int i = 0; i < stall; i++) begin r.rdy = 1'b0; q.push_back(r); end
    r.rdy = 1'b1; q.push_back(r);
    r.st = ST_PL_C; r.stb = S_INC_PC | S_MDR_OUT; r.rrd = 16'h1 << sel; q.push_back(r);
  endfunction

  function automatic void gen_stuck();
`ifdef CTRL_WATCHDOG_EN
    rec_t r;
    r = base();
    r.ir = {5'b00011, 27'h0};
    r.st = ST_IDLE; r.start = 1'b1; q.push_back(r); r.start = 1'b0;
    r.st = ST_T0; r.stb = S_PC_OUT | S_MAR_IN | S_INC_PC | S_ZLO_IN; q.push_back(r);
    r.st = ST_T1; r.stb = S_ZLO_OUT | S_PC_IN | S_READ | S_MDR_IN; r.rdy = 1'b0;
    for (int i = 0; i < WD; i++) q.push_back(r);
    flt_m = 1'b1;
`else
    gen_instr(5'b00110, 20, 1'b0, 1'b0);
`endif
    gen_idle();
  endfunction

  task automatic run_q();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      start = r.start; run = r.run; preload_req = r.preq;
      preload_sel = r.sel; mem_rdy = r.rdy; ir = r.ir;
      chk("step",    32'(step),    32'(r.st));
      chk("strobes", 32'(stb_act), 32'(r.stb));
      chk("op_sel",  32'(op_sel),  32'(r.ops));
      chk("r_rd",    32'(r_rd),    32'(r.rrd));
      chk("done",    32'(done),    32'(r.done));
      chk("busy",    32'(busy),    32'(r.st != ST_IDLE));
      chk("illegal", 32'(illegal), 32'(r.ill));
      chk("fault",   32'(fault),   32'(r.flt));
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_step"},    32'(step),    32'(ST_IDLE));
    chk({tag, "_strobes"}, 32'(stb_act), 32'h0);
    chk({tag, "_op_sel"},  32'(op_sel),  32'h0);
    chk({tag, "_r_rd"},    32'(r_rd),    32'h0);
    chk({tag, "_busy"},    32'(busy),    32'h0);
    chk({tag, "_done"},    32'(done),    32'h0);
    chk({tag, "_illegal"}, 32'(illegal), 32'h0);
    chk({tag, "_fault"},   32'(fault),   32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b0; start = 1'b0; run = 1'b0; preload_req = 1'b0;
    preload_sel = 4'h0; mem_rdy = 1'b1; ir = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    clr = 1'b1;
    @(posedge clk); #1;

    // Preload of r5, then preload beating a simultaneous start, with a stall.
    gen_preload(4'd5, 0, 1'b0);
    gen_idle();
    gen_preload(4'd2, 2, 1'b1);
    gen_idle();
    // andi, sub, add with a 3-cycle fetch stall, illegal, run chain, held start.
    gen_instr(5'b01101, 0, 1'b0, 1'b0);
    gen_instr(5'b00100, 0, 1'b0, 1'b0);
    gen_instr(5'b00011, 3, 1'b0, 1'b0);
    gen_instr(5'b11111, 0, 1'b0, 1'b0);
    gen_instr(5'b00011, 0, 1'b1, 1'b0);
    gen_instr(5'b01110, 1, 1'b0, 1'b1);
    gen_instr(5'b00110, 0, 1'b0, 1'b1);
    gen_idle();
    run_q();

    // Randomized mix of preloads and instructions.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0 && !chain_m)
        gen_preload(4'($urandom), $urandom_range(0, 3), 1'($urandom));
      else
        gen_instr(pick_op($urandom_range(0, 7)), $urandom_range(0, 3),
                  (n < 29) && ($urandom_range(0, 2) == 0), 1'($urandom));
    end
    gen_idle();
    run_q();

    // Asynchronous reset while in T4.
    gen_instr(5'b00011, 0, 1'b0, 1'b0);
    tmp = q.pop_back();
    tmp = q.pop_back();
    run_q();
    chk("pre_rst_step",   32'(step),   32'(ST_T4));
    chk("pre_rst_op_sel", 32'(op_sel), 32'h3);
    clr = 1'b0;
    #1;
    chk_all_zero("async_rst");
    clr = 1'b1; start = 1'b0; run = 1'b0; preload_req = 1'b0; mem_rdy = 1'b1;
    ill_m = 1'b0; flt_m = 1'b0; chain_m = 1'b0;
    @(posedge clk); #1;

    // Memory stuck not-ready in T1.
    gen_stuck();
    run_q();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
